regfile_mp_sb: RTL

//  Multi-ported integer register file with a pending-write scoreboard and N-source operand forwarding.

---
 rtl/regfile_mp_sb.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb
//   Multi-ported integer register file for the ID stage. It serves NRD operands
//   per cycle with per-operand ready flags, takes NWR commits from WB, and keeps
//   a pending-writer scoreboard so issue can stall on RAW hazards. Operands are
//   forwarded from NFWD in-flight sources. Source 0 is the youngest stage and
//   has the highest priority.
//
// Ports
//   clk, rst     clock (rising edge) and synchronous active-high reset
//   wr_en/addr/data       commit ports from WB (highest index wins on same reg)
//   alloc_en/addr         issue-time destination allocation (counter increment)
//   rd_en/addr            operand read requests
//   rd_data/rd_ready      combinational operand value and validity
//   fwd_en/valid/addr/data  forwarding sources, index 0 highest priority
//   busy_vec              registered: bit r set while reg r has pending writers
//   sb_ovf                sticky: allocation hit a saturated counter
module regfile_mp_sb #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int NRD    = 4,
  parameter int NWR    = 2,
  parameter int NFWD   = 4,
  parameter int CNT_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR*AW-1:0]      wr_addr,
  input  logic [NWR*DATA_W-1:0]  wr_data,
  input  logic [NWR-1:0]         alloc_en,
  input  logic [NWR*AW-1:0]      alloc_addr,
  input  logic [NRD-1:0]         rd_en,
  input  logic [NRD*AW-1:0]      rd_addr,
  output logic [NRD*DATA_W-1:0]  rd_data,
  output logic [NRD-1:0]         rd_ready,
  input  logic [NFWD-1:0]        fwd_en,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD*AW-1:0]     fwd_addr,
  input  logic [NFWD*DATA_W-1:0] fwd_data,
  output logic [(2**AW)-1:0]     busy_vec,
  output logic                   sb_ovf
);

  localparam int NREG = 2 ** AW;
  // Wide enough that count + NWR never wraps before the saturation test.
  localparam int SW = CNT_W + $clog2(NWR + 1) + 1;
  localparam logic [SW-1:0] CMAX = SW'((2 ** CNT_W) - 1);

  logic [DATA_W-1:0] r_rf [NREG];
  logic [CNT_W-1:0]  r_cnt [NREG];
  logic [NREG-1:0]   r_busy_vec;
  logic              r_sb_ovf;

  logic [CNT_W-1:0]  w_cnt_next [NREG];
  logic [NREG-1:0]   w_busy_next;
  logic [NREG-1:0]   w_ovf_hit;

  // ---------------------------------------------------------------------------
  // Scoreboard next-state, one slice per register
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        // r0 is hard-wired: never counted, never busy.
        assign w_cnt_next[gi]  = '0;
        assign w_ovf_hit[gi]   = 1'b0;
        assign w_busy_next[gi] = 1'b0;
      end else begin : g_reg
        logic [SW-1:0] w_na;
        logic [SW-1:0] w_nw;
        logic [SW-1:0] w_sum;
        logic [SW-1:0] w_diff;
        logic [CNT_W-1:0] w_cnt;
        logic w_ovf;

        always_comb begin
          w_na = '0;
          w_nw = '0;
          for (int i = 0; i < NWR; i++) begin
            if (alloc_en[i] && (alloc_addr[i*AW +: AW] == AW'(gi)))
              w_na = w_na + SW'(1);
            if (wr_en[i] && (wr_addr[i*AW +: AW] == AW'(gi)))
              w_nw = w_nw + SW'(1);
          end
        end

        // Evaluate count + allocs - commits without going negative: compare
        // before subtracting, so underflow (commit without alloc) clamps to 0.
        always_comb begin
          w_sum  = SW'(r_cnt[gi]) + w_na;
          w_diff = '0;
          w_cnt  = '0;
          w_ovf  = 1'b0;
          if (w_sum >= w_nw) begin
            w_diff = w_sum - w_nw;
            if (w_diff > CMAX) begin
              w_cnt = CMAX[CNT_W-1:0];
              w_ovf = 1'b1;
            end else begin
              w_cnt = w_diff[CNT_W-1:0];
            end
          end
        end

        assign w_cnt_next[gi]  = w_cnt;
        assign w_ovf_hit[gi]   = w_ovf;
        assign w_busy_next[gi] = |w_cnt;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
      r_busy_vec <= '0;
      r_sb_ovf   <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= w_cnt_next[r];
      r_busy_vec <= w_busy_next;
      if (|w_ovf_hit) r_sb_ovf <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Register storage: ascending port loop so the highest index wins a tie
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) r_rf[r] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i] && (wr_addr[i*AW +: AW] != '0))
          r_rf[wr_addr[i*AW +: AW]] <= wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: forwarding, then same-cycle commit bypass, then the array
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]     w_addr;
      logic              w_fhit;
      logic              w_fvalid;
      logic [DATA_W-1:0] w_fdata;
      logic              w_whit;
      logic [DATA_W-1:0] w_wdata;
      logic [DATA_W-1:0] w_data;
      logic              w_rdy;

      assign w_addr = rd_addr[gi*AW +: AW];

      always_comb begin
        w_fhit   = 1'b0;
        w_fvalid = 1'b0;
        w_fdata  = '0;
        // Descending scan: the lowest matching index is written last and wins.
        // Only the address match decides, so a not-yet-valid young source
        // correctly hides an older valid one.
        for (int j = NFWD - 1; j >= 0; j--) begin
          if (fwd_en[j] && (fwd_addr[j*AW +: AW] == w_addr)) begin
            w_fhit   = 1'b1;
            w_fvalid = fwd_valid[j];
            w_fdata  = fwd_data[j*DATA_W +: DATA_W];
          end
        end
      end

      always_comb begin
        w_whit  = 1'b0;
        w_wdata = '0;
        for (int i = 0; i < NWR; i++) begin
          if (wr_en[i] && (wr_addr[i*AW +: AW] == w_addr)) begin
            w_whit  = 1'b1;
            w_wdata = wr_data[i*DATA_W +: DATA_W];
          end
        end
      end

      always_comb begin
        w_data = '0;
        w_rdy  = 1'b0;
        if (!rst && rd_en[gi]) begin
          if (w_addr == '0) begin
            w_rdy = 1'b1;
          end else if (w_fhit) begin
            w_data = w_fdata;
            w_rdy  = w_fvalid;
          end else if (w_whit) begin
            w_data = w_wdata;
            w_rdy  = 1'b1;
          end else begin
            w_data = r_rf[w_addr];
            w_rdy  = (r_cnt[w_addr] == '0);
          end
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = w_data;
      assign rd_ready[gi]                 = w_rdy;
    end
  endgenerate

  assign busy_vec = r_busy_vec;
  assign sb_ovf   = r_sb_ovf;

endmodule
